multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of mem_ready wait cycles per access; 0 disables the timeout.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 opcode  input  7  instruction bits [6:0].
REQ-007 funct3  input  3  instruction bits [14:12].
REQ-008 branch_taken  input  1  branch comparison result from the datapath.
REQ-009 mem_ready  input  1  memory completes the current access.
REQ-010 trap_clr  input  1  leave TRAP.
REQ-011 mem_req  output  1  memory access request.
REQ-012 mem_we  output  1  the access is a write.
REQ-013 mem_size  output  3  access size: 001 = byte, 010 = half, 100 = word.
REQ-014 mem_unsigned  output  1  zero-extend the load.
REQ-015 ir_write, pc_write, reg_write  outputs  1 each  single-cycle write strobes.
REQ-016 alu_src  output  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-017 alu_op  output  2  ALU class: 00 = add, 01 = I, 10 = R, 11 = branch.
REQ-018 wb_sel  output  3  write-back source: 000 = ALU, 001 = memory, 010 = PC+4, 011 = immediate, 100 = PC+immediate.
REQ-019 pc_sel  output  2  next-PC source: 00 = PC+4, 01 = JAL target, 10 = JALR target, 11 = branch target.
REQ-020 illegal_inst, bus_err  outputs  1 each  trap cause, valid while in TRAP.
REQ-021 instret  output  CNT_W  retired-instruction count.

Function
REQ-022 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-023 Every output SHALL be decoded from the current state and the latched opcode/funct3; no output may depend combinationally on mem_ready except ir_write and pc_write.
REQ-024 IDLE SHALL drive all outputs to 0 and SHALL go to FETCH on the next cycle.
REQ-025 FETCH SHALL assert mem_req with mem_size=100 and mem_we=0.
REQ-026 In FETCH, the cycle with mem_ready=1 SHALL assert ir_write and SHALL move to DECODE.
REQ-027 DECODE SHALL latch opcode and funct3.
REQ-028 DECODE SHALL go to WB for LUI (0110111) and AUIPC (0010111).
REQ-029 DECODE SHALL go to EXEC for JAL, JALR, B-type, I-type, R-type, load and store.
REQ-030 DECODE SHALL go to TRAP with illegal_inst=1 for any other opcode, for a load with funct3 in {011, 110, 111}, and for a store with funct3 > 010.
REQ-031 EXEC SHALL drive alu_op/alu_src as follows: R = 10/0, I = 01/1, B = 11/0, load/store/JALR = 00/1, JAL = 00/0.
REQ-032 EXEC SHALL go to MEM for loads and stores, and to WB otherwise.
REQ-033 For a B-type instruction, EXEC SHALL instead pulse pc_write with pc_sel = 11 if branch_taken, else 00, and SHALL return to FETCH.
REQ-034 MEM SHALL assert mem_req and SHALL set mem_size by funct3: 000/100 = 001, 001/101 = 010, 010 = 100.
REQ-035 MEM SHALL set mem_unsigned = funct3[2] for loads and mem_we = 1 for stores.
REQ-036 In MEM, on mem_ready=1 a load SHALL go to WB; a store SHALL pulse pc_write (pc_sel = 00) and go to FETCH.
REQ-037 WB SHALL pulse reg_write with wb_sel: LUI 011, AUIPC 100, JAL/JALR 010, load 001, R/I 000.
REQ-038 WB SHALL pulse pc_write with pc_sel: JAL 01, JALR 10, all others 00, and SHALL go to FETCH.
REQ-039 An instruction retires in exactly the cycle its pc_write pulses.
REQ-040 instret SHALL increment by 1 on each retirement, wrap modulo 2^CNT_W, and never count trapped instructions.
REQ-041 An internal wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 with mem_ready=0.
REQ-042 If TIMEOUT > 0 and the wait counter reaches TIMEOUT with mem_ready=0, the block SHALL go to TRAP with bus_err=1, dropping mem_req.
REQ-043 mem_ready in the same cycle the counter reaches TIMEOUT SHALL complete the access normally; completion wins over timeout.
REQ-044 TRAP SHALL hold all strobes at 0 and keep illegal_inst/bus_err stable until trap_clr=1, then go to FETCH and clear both.
REQ-045 mem_ready outside FETCH/MEM and trap_clr outside TRAP SHALL be ignored.

Reset
REQ-046 rst_n=0 SHALL force state IDLE immediately and clear instret, the wait counter, the latched fields, illegal_inst and bus_err.
REQ-047 Every output SHALL be 0 during reset and in the first cycle after release.
REQ-048 Reset asserted mid-access SHALL abandon the access, and mem_req SHALL fall asynchronously.

Verification
REQ-049 ADD (0110011), mem_ready=1 on the first FETCH cycle -> IDLE, FETCH, DECODE, EXEC (alu_op=10), WB (reg_write=1, wb_sel=000, pc_write=1); instret=1.
REQ-050 LW (0000011, funct3=010), MEM waits 3 cycles -> mem_size=100 held 4 cycles, then WB wb_sel=001; LHU gives mem_size=010, mem_unsigned=1.
REQ-051 BEQ, branch_taken=1 -> pc_write in EXEC with pc_sel=11, no reg_write; with branch_taken=0 -> pc_sel=00.
REQ-052 Opcode 1111111, or load funct3=011 -> TRAP, illegal_inst=1, instret unchanged; trap_clr=1 -> FETCH, flags 0.
REQ-053 TIMEOUT=4, mem_ready held 0 -> bus_err=1 after 4 wait cycles; a repeat run with mem_ready=1 on the 4th cycle completes normally.
REQ-054 Reset pulsed during MEM wait -> outputs 0 immediately; after release, IDLE then FETCH, instret=0.

Source files
------------

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle RV32I-style datapath.
// Sequence: IDLE -> FETCH -> DECODE -> (EXEC) -> (MEM) -> (WB) -> FETCH.
// Illegal encodings and memory timeouts park the FSM in TRAP until trap_clr.
//
// Memory handshake: mem_req is a request held high for the whole access.
// The access completes in the first cycle where mem_req=1 and mem_ready=1.
// mem_ready has no effect while mem_req=0.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   opcode, funct3           instruction fields (sampled in DECODE)
//   branch_taken             branch comparison result from the datapath
//   mem_ready                memory completes the current access
//   trap_clr                 leave TRAP
//   mem_req/mem_we/mem_size/mem_unsigned   memory access control
//   ir_write/pc_write/reg_write            single-cycle write strobes
//   alu_src/alu_op           ALU operand and class select
//   wb_sel/pc_sel            write-back and next-PC source select
//   illegal_inst/bus_err     trap cause, valid while in TRAP
//   instret                  retired-instruction counter
//   dbg_state                current FSM state
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             trap_clr,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       mem_size,
    output logic             mem_unsigned,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       wb_sel,
    output logic [1:0]       pc_sel,
    output logic             illegal_inst,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       dbg_state
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    // The counter must be able to hold TIMEOUT itself.
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the counter in the last cycle an access may still complete.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        opc_q, opc_d;
    logic [2:0]        f3_q, f3_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ill_q, ill_d;
    logic              berr_q, berr_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              wait_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            f3_q      <= '0;
            wait_q    <= '0;
            ill_q     <= 1'b0;
            berr_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            f3_q      <= f3_d;
            wait_q    <= wait_d;
            ill_q     <= ill_d;
            berr_q    <= berr_d;
            instret_q <= instret_d;
        end
    end

    // This cycle is the last permitted wait cycle and memory is still busy.
    // A mem_ready in the same cycle takes priority (checked first below).
    assign wait_expire = (TIMEOUT > 0) && (wait_q == WAIT_LAST) && !mem_ready;

    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        f3_d         = f3_q;
        ill_d        = ill_q;
        berr_d       = berr_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_size     = 3'b000;
        mem_unsigned = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        wb_sel       = 3'b000;
        pc_sel       = 2'b00;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_size = 3'b100;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expire) begin
                    berr_d  = 1'b1;
                    state_d = S_TRAP;
                end
            end

            S_DECODE: begin
                // Routing uses the live fields; later states use the latched copy.
                opc_d = opcode;
                f3_d  = funct3;
                case (opcode)
                    OP_LUI, OP_AUIPC: state_d = S_WB;
                    OP_JAL, OP_JALR, OP_BR, OP_IMM, OP_REG: state_d = S_EXEC;
                    OP_LOAD: begin
                        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                            ill_d   = 1'b1;
                            state_d = S_TRAP;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    OP_STORE: begin
                        if (funct3 > 3'b010) begin
                            ill_d   = 1'b1;
                            state_d = S_TRAP;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    default: begin
                        ill_d   = 1'b1;
                        state_d = S_TRAP;
                    end
                endcase
            end

            S_EXEC: begin
                state_d = S_WB;
                case (opc_q)
                    OP_REG: begin
                        alu_op  = 2'b10;
                        alu_src = 1'b0;
                    end
                    OP_IMM: begin
                        alu_op  = 2'b01;
                        alu_src = 1'b1;
                    end
                    OP_BR: begin
                        // Branches retire here; they never write a register.
                        alu_op   = 2'b11;
                        alu_src  = 1'b0;
                        pc_write = 1'b1;
                        pc_sel   = branch_taken ? 2'b11 : 2'b00;
                        state_d  = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op  = 2'b00;
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_JALR: begin
                        alu_op  = 2'b00;
                        alu_src = 1'b1;
                    end
                    default: begin
                        alu_op  = 2'b00;
                        alu_src = 1'b0;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                case (f3_q[1:0])
                    2'b00:   mem_size = 3'b001;
                    2'b01:   mem_size = 3'b010;
                    default: mem_size = 3'b100;
                endcase
                if (opc_q == OP_LOAD) begin
                    mem_unsigned = f3_q[2];
                end else begin
                    mem_we = 1'b1;
                end
                if (mem_ready) begin
                    if (opc_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        // Stores retire on completion of the write.
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (wait_expire) begin
                    berr_d  = 1'b1;
                    state_d = S_TRAP;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
                case (opc_q)
                    OP_LUI:   wb_sel = 3'b011;
                    OP_AUIPC: wb_sel = 3'b100;
                    OP_JAL: begin
                        wb_sel = 3'b010;
                        pc_sel = 2'b01;
                    end
                    OP_JALR: begin
                        wb_sel = 3'b010;
                        pc_sel = 2'b10;
                    end
                    OP_LOAD:  wb_sel = 3'b001;
                    default:  wb_sel = 3'b000;
                endcase
            end

            S_TRAP: begin
                if (trap_clr) begin
                    ill_d   = 1'b0;
                    berr_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter: restarts on entry to a memory state, counts busy cycles.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
            wait_d = '0;
        end else if (mem_req && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Retirement coincides exactly with the pc_write pulse.
    always_comb begin
        instret_d = instret_q;
        if (pc_write) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    assign illegal_inst = ill_q;
    assign bus_err      = berr_q;
    assign instret      = instret_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//
// Drives whole instructions through multicycle_control and compares every
// cycle's outputs against a phase-level model of the instruction lifecycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          branch_taken = 1'b0;
    logic          mem_ready = 1'b0;
    logic          trap_clr = 1'b0;
    logic          mem_req, mem_we, mem_unsigned;
    logic [2:0]    mem_size;
    logic          ir_write, pc_write, reg_write, alu_src;
    logic [1:0]    alu_op;
    logic [2:0]    wb_sel;
    logic [1:0]    pc_sel;
    logic          illegal_inst, bus_err;
    logic [CW-1:0] instret;
    logic [2:0]    dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .trap_clr(trap_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
        .wb_sel(wb_sel), .pc_sel(pc_sel), .illegal_inst(illegal_inst),
        .bus_err(bus_err), .instret(instret), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       mem_unsigned;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [2:0] wb_sel;
        logic [1:0] pc_sel;
        logic       illegal_inst;
        logic       bus_err;
    } outs_t;

    typedef enum int {C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_I, C_R, C_LD, C_ST, C_ILL} cls_t;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;   // model count of retired instructions since last reset

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (state %0d, t=%0t)", tag, got, exp, dbg_state, $time);
        end
    endtask

    function automatic outs_t act();
        outs_t a;
        a.mem_req = mem_req;           a.mem_we = mem_we;
        a.mem_size = mem_size;         a.mem_unsigned = mem_unsigned;
        a.ir_write = ir_write;         a.pc_write = pc_write;
        a.reg_write = reg_write;       a.alu_src = alu_src;
        a.alu_op = alu_op;             a.wb_sel = wb_sel;
        a.pc_sel = pc_sel;             a.illegal_inst = illegal_inst;
        a.bus_err = bus_err;
        return a;
    endfunction

    task automatic chk_out(input string tag, input outs_t e);
        #1;
        check(tag, 32'(act()), 32'(e));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model (instruction-level rules) ----------------
    function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0010011: return C_I;
            7'b0110011: return C_R;
            7'b0000011: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? C_ILL : C_LD;
            7'b0100011: return (f3 > 3'd2) ? C_ILL : C_ST;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [1:0] aop(input cls_t c);
        case (c)
            C_R:     return 2'b10;
            C_I:     return 2'b01;
            C_BR:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic asrc(input cls_t c);
        return (c == C_I || c == C_LD || c == C_ST || c == C_JALR);
    endfunction

    function automatic logic [2:0] wbs(input cls_t c);
        case (c)
            C_LUI:         return 3'b011;
            C_AUIPC:       return 3'b100;
            C_JAL, C_JALR: return 3'b010;
            C_LD:          return 3'b001;
            default:       return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] pcs(input cls_t c);
        case (c)
            C_JAL:   return 2'b01;
            C_JALR:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // ---------------- drivers ----------------
    // Inputs that must have no effect in the current state.
    task automatic noise();
        mem_ready = 1'($urandom);
        trap_clr  = 1'($urandom);
    endtask

    task automatic retire();
        exp_ret++;
        check("instret", 32'(instret), 32'(exp_ret % (1 << CW)));
    endtask

    // One memory access: ready arrives on cycle index nwait; at most TO cycles.
    task automatic mem_phase(input string tag, input outs_t base, input outs_t on_rdy,
                             input int nwait, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < TO; k++) begin
            trap_clr = 1'($urandom);
            if (k == nwait) begin
                mem_ready = 1'b1;
                chk_out(tag, base | on_rdy);
                step();
                ok = 1'b1;
                break;
            end
            mem_ready = 1'b0;
            chk_out(tag, base);
            step();
        end
    endtask

    task automatic trap_phase(input bit ill, input bit be);
        outs_t e;
        int    hold;
        e = '0;
        e.illegal_inst = ill;
        e.bus_err = be;
        hold = $urandom_range(0, 2);
        for (int k = 0; k < hold; k++) begin
            mem_ready = 1'($urandom);
            trap_clr = 1'b0;
            chk_out("trap_hold", e);
            step();
        end
        trap_clr = 1'b1;
        chk_out("trap_clr", e);
        step();
        trap_clr = 1'b0;
        check("trap_instret", 32'(instret), 32'(exp_ret % (1 << CW)));
    endtask

    // Starts and ends on a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit taken,
                             input int fw, input int mw);
        outs_t e, rdy;
        bit    ok;
        cls_t  c;
        c = classify(op, f3);

        e = '0; e.mem_req = 1'b1; e.mem_size = 3'b100;
        rdy = '0; rdy.ir_write = 1'b1;
        mem_phase("fetch", e, rdy, fw, ok);
        if (!ok) begin
            trap_phase(1'b0, 1'b1);
            return;
        end

        opcode = op;
        funct3 = f3;
        noise();
        chk_out("decode", '0);
        step();
        // Scramble the live fields: later phases must use the latched copy.
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
        if (c == C_ILL) begin
            trap_phase(1'b1, 1'b0);
            return;
        end

        if (c != C_LUI && c != C_AUIPC) begin
            e = '0;
            e.alu_op = aop(c);
            e.alu_src = asrc(c);
            branch_taken = (c == C_BR) ? taken : 1'($urandom);
            if (c == C_BR) begin
                e.pc_write = 1'b1;
                e.pc_sel = taken ? 2'b11 : 2'b00;
            end
            noise();
            chk_out("exec", e);
            step();
            if (c == C_BR) begin
                retire();
                return;
            end
            if (c == C_LD || c == C_ST) begin
                e = '0;
                e.mem_req = 1'b1;
                e.mem_we = (c == C_ST);
                e.mem_size = size_of(f3);
                e.mem_unsigned = (c == C_LD) && f3[2];
                rdy = '0;
                rdy.pc_write = (c == C_ST);
                mem_phase("mem", e, rdy, mw, ok);
                if (!ok) begin
                    trap_phase(1'b0, 1'b1);
                    return;
                end
                if (c == C_ST) begin
                    retire();
                    return;
                end
            end
        end

        e = '0;
        e.reg_write = 1'b1;
        e.wb_sel = wbs(c);
        e.pc_write = 1'b1;
        e.pc_sel = pcs(c);
        noise();
        chk_out("wb", e);
        step();
        retire();
    endtask

    // Reset asserted while a load waits in MEM.
    task automatic reset_in_mem();
        outs_t e;
        mem_ready = 1'b1;
        step();                        // FETCH completes
        opcode = 7'b0000011;
        funct3 = 3'b010;
        mem_ready = 1'b0;
        step();                        // DECODE
        step();                        // EXEC
        e = '0; e.mem_req = 1'b1; e.mem_size = 3'b100;
        chk_out("mem_before_rst", e);
        #1;
        rst_n = 1'b0;
        chk_out("rst_async", '0);
        check("rst_instret", 32'(instret), 32'd0);
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_out("idle_after_rst", '0);
        step();                        // now in FETCH
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011};

    initial begin
        logic [6:0] op;
        int fw, mw;

        repeat (2) @(negedge clk);
        chk_out("reset_outs", '0);
        check("reset_instret", 32'(instret), 32'd0);
        rst_n = 1'b1;
        chk_out("idle", '0);
        step();

        // Directed cases
        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0);   // ADD
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 3);   // LW, 3 wait cycles
        run_instr(7'b0000011, 3'b101, 1'b0, 1, 1);   // LHU
        run_instr(7'b0100011, 3'b000, 1'b0, 2, 0);   // SB
        run_instr(7'b1100011, 3'b000, 1'b1, 0, 0);   // BEQ taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);   // BEQ not taken
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);   // illegal opcode
        run_instr(7'b0000011, 3'b011, 1'b0, 0, 0);   // illegal load width
        run_instr(7'b0100011, 3'b011, 1'b0, 0, 0);   // illegal store width
        run_instr(7'b0110011, 3'b000, 1'b0, 9, 0);   // fetch timeout
        run_instr(7'b0110011, 3'b000, 1'b0, 3, 0);   // ready on last allowed fetch cycle
        run_instr(7'b0000011, 3'b000, 1'b0, 0, 9);   // MEM timeout
        run_instr(7'b1101111, 3'b000, 1'b0, 0, 0);   // JAL
        run_instr(7'b1100111, 3'b000, 1'b0, 0, 0);   // JALR
        run_instr(7'b0110111, 3'b000, 1'b0, 0, 0);   // LUI
        run_instr(7'b0010111, 3'b000, 1'b0, 0, 0);   // AUIPC
        reset_in_mem();
        run_instr(7'b0010011, 3'b000, 1'b0, 0, 0);   // ADDI after reset

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            run_instr(op, 3'($urandom), 1'($urandom), fw, mw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
